// File: rtl/mantissa_seq_multiplier.sv
// mantissa_seq_multiplier: iterative MSB-first shift-add unsigned mantissa multiplier with sign tag
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; mant_a, mant_b, sign_a, sign_b sampled on it
//   out_valid/out_ready result handshake; product (exact mant_a*mant_b), res_sign (sign_a^sign_b)
//   busy                high while a multiplication is in flight or awaiting hand-off
// Build option:
//   MUL_EARLY_TERM_EN   finish as soon as the remaining multiplier bits are all zero
module mantissa_seq_multiplier #(
    parameter int IS_DOUBLE  = 0,
    parameter int MANT_WIDTH = IS_DOUBLE ? 53 : 24,
    parameter int PROD_WIDTH = 2 * MANT_WIDTH,
    parameter int CNT_WIDTH  = $clog2(MANT_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_WIDTH-1:0] mant_a,
    input  logic [MANT_WIDTH-1:0] mant_b,
    input  logic                  sign_a,
    input  logic                  sign_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PROD_WIDTH-1:0] product,
    output logic                  res_sign,
    output logic                  busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [MANT_WIDTH-1:0] a_reg, b_reg;
    logic [PROD_WIDTH-1:0] acc, step, acc_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  last;

    assign step = (acc << 1) + (b_reg[cnt] ? PROD_WIDTH'(a_reg) : '0);

`ifdef MUL_EARLY_TERM_EN
    logic [MANT_WIDTH-1:0] low_mask;
    // Once no set multiplier bits remain below i, the rest of the shift-add
    // collapses to a single left shift by i.
    always_comb begin
        low_mask = (MANT_WIDTH'(1) << cnt) - MANT_WIDTH'(1);
        last     = ~|(b_reg & low_mask);
        acc_next = last ? step << cnt : step;
    end
`else
    assign last     = (cnt == '0);
    assign acc_next = step;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            product  <= '0;
            res_sign <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_reg    <= mant_a;
                b_reg    <= mant_b;
                res_sign <= sign_a ^ sign_b;
                acc      <= '0;
                cnt      <= CNT_WIDTH'(MANT_WIDTH - 1);
                state    <= CALC;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (last) begin
                product <= acc_next;
                state   <= DONE;
            end
        end else if (state == DONE) begin
            if (out_ready)
                state <= IDLE;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mantissa_seq_multiplier.sv
// tb_mantissa_seq_multiplier: directed self-checking bench for single and double mantissa multipliers
module tb_mantissa_seq_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, out_ready = 1'b0, sign_a = 1'b0, sign_b = 1'b0;
    logic [23:0] mant_a = '0, mant_b = '0;
    logic        in_ready, out_valid, res_sign, busy;
    logic [47:0] product;

    logic        d_in_valid = 1'b0, d_out_ready = 1'b0;
    logic [52:0] d_mant_a = '0, d_mant_b = '0;
    logic        d_in_ready, d_out_valid, d_res_sign, d_busy;
    logic [105:0] d_product;

    mantissa_seq_multiplier #(.IS_DOUBLE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mant_a(mant_a), .mant_b(mant_b), .sign_a(sign_a), .sign_b(sign_b),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .res_sign(res_sign), .busy(busy)
    );

    mantissa_seq_multiplier #(.IS_DOUBLE(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .mant_a(d_mant_a), .mant_b(d_mant_b), .sign_a(1'b1), .sign_b(1'b1),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .product(d_product),
        .res_sign(d_res_sign), .busy(d_busy)
    );

`ifdef MUL_EARLY_TERM_EN
    localparam int LAT1 = 1;
    localparam int LAT5 = 1;
`else
    localparam int LAT1 = 24;
    localparam int LAT5 = 53;
`endif

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op on the single-precision DUT; returns clocks from accept to out_valid.
    task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                          input logic sa, input logic sb, output int lat);
        int k;
        @(negedge clk);
        mant_a = a; mant_b = b; sign_a = sa; sign_b = sb; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); lat++; @(negedge clk); end while (!out_valid && lat < 200);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", out_valid, 1'b0);
        chk("release_in_ready", in_ready, 1'b1);
    endtask

    logic [23:0] va [6] = '{24'h000001, 24'h000000, 24'h800000, 24'h000010, 24'hC00000, 24'h123456};
    logic [23:0] vb [6] = '{24'h000001, 24'hABCDEF, 24'h000003, 24'h000010, 24'h800000, 24'h000100};
    logic [47:0] vp [6] = '{48'h0000_0000_0001, 48'h0, 48'h0000_0180_0000,
                            48'h0000_0000_0100, 48'h6000_0000_0000, 48'h0000_1234_5600};
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int lat, k, last_cyc;
        logic [47:0] held;
        logic [105:0] dexp;
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_product", product, 48'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(24'h800000, 24'h800000, 1'b0, 1'b0, lat);
        chk("t1_latency", lat, LAT1);
        chk("t1_product", product, 48'h4000_0000_0000);
        chk("t1_sign", res_sign, 1'b0);
        chk("t1_busy", busy, 1'b1);
        release_out();

        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, lat);
        chk("t2_latency", lat, 24);
        chk("t2_product", product, 48'hFFFF_FE00_0001);
        chk("t2_sign", res_sign, 1'b1);

        held = product;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            mant_a = 24'h000003; mant_b = 24'h000005; sign_b = 1'b1;
            @(negedge clk);
            chk("t3_out_valid", out_valid, 1'b1);
            chk("t3_product", product, held);
            chk("t3_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        chk("t3_sign", res_sign, 1'b1);
        release_out();
        chk("t3_not_accepted", busy, 1'b0);

        @(negedge clk);
        mant_a = 24'h123456; mant_b = 24'hFFFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_out_valid", out_valid, 1'b0);
        chk("t4_product", product, 48'h0);
        chk("t4_in_ready", in_ready, 1'b1);
        chk("t4_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(24'h000010, 24'h000010, 1'b1, 1'b1, lat);
        chk("t4_new_product", product, 48'h0000_0000_0100);
        chk("t4_new_sign", res_sign, 1'b0);
        release_out();

        @(negedge clk);
        d_mant_a = 53'h10_0000_0000_0001; d_mant_b = 53'h10_0000_0000_0000; d_in_valid = 1'b1;
        dexp = 106'(d_mant_a) << 52;
        k = 0;
        while (!d_in_ready && k < 100) begin @(negedge clk); k++; end
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); lat++; @(negedge clk); end while (!d_out_valid && lat < 200);
        chk("t5_latency", lat, LAT5);
        chk("t5_product", d_product, dexp);
        chk("t5_sign", d_res_sign, 1'b0);
        d_out_ready = 1'b1;
        @(negedge clk);
        chk("t5_release", d_out_valid, 1'b0);

        out_ready = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            mant_a = va[i]; mant_b = vb[i]; sign_a = vs[i]; sign_b = 1'b0; in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 100) begin @(negedge clk); k++; end
            @(posedge clk);
            #1;
            lat = 0;
            do begin @(posedge clk); lat++; @(negedge clk); end while (!out_valid && lat < 200);
            chk($sformatf("t6_product_%0d", i), product, vp[i]);
            chk($sformatf("t6_sign_%0d", i), res_sign, vs[i]);
`ifndef MUL_EARLY_TERM_EN
            if (i > 0) chk($sformatf("t6_interval_%0d", i), cyc - last_cyc, 26);
`endif
            last_cyc = cyc;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
